// File: rtl/vending_controller.sv
// Coin-operated vending controller: edge-detects coin sensors, accumulates
// credit, vends at PRICE and pays change or refunds one nickel per cycle.
module vending_controller #(
  parameter int unsigned PRICE       = 60,
  parameter int unsigned NICKEL_VAL  = 5,
  parameter int unsigned DIME_VAL    = 10,
  parameter int unsigned QUARTER_VAL = 25,
  parameter int unsigned CREDIT_W    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  output logic                dispenseNoBalance,
  output logic                dispenseBalance,
  output logic                changeNickel,
  output logic                coinReject,
  output logic                busy,
  output logic [CREDIT_W-1:0] count
);

  localparam int unsigned CW1 = CREDIT_W + 1;

  localparam logic [CREDIT_W:0]   PRICE_X   = CW1'(PRICE);
  localparam logic [CREDIT_W:0]   NICKEL_X  = CW1'(NICKEL_VAL);
  localparam logic [CREDIT_W:0]   DIME_X    = CW1'(DIME_VAL);
  localparam logic [CREDIT_W:0]   QUARTER_X = CW1'(QUARTER_VAL);
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C    = CREDIT_W'(5);

  typedef enum logic [1:0] {
    COLLECT,
    DISPENSE,
    CHANGE
  } state_t;

  state_t          state;
  logic [2:0]      prev;      // {nickel, dime, quarter} from the previous clock
  logic [2:0]      rise;
  logic            any_coin;
  logic            one_coin;
  logic [CREDIT_W:0] coin_val;
  logic [CREDIT_W:0] sum;

  always_comb begin
    rise     = {nickel, dime, quarter} & ~prev;
    any_coin = |rise;
    one_coin = $onehot(rise);
    case (rise)
      3'b100:  coin_val = NICKEL_X;
      3'b010:  coin_val = DIME_X;
      3'b001:  coin_val = QUARTER_X;
      default: coin_val = '0;
    endcase
    // One extra bit so the PRICE comparison can never see a wrapped credit.
    sum = {1'b0, count} + coin_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= COLLECT;
      count             <= '0;
      prev              <= '1;
      dispenseNoBalance <= 1'b0;
      dispenseBalance   <= 1'b0;
      changeNickel      <= 1'b0;
      coinReject        <= 1'b0;
      busy              <= 1'b0;
    end else begin
      prev              <= {nickel, dime, quarter};
      dispenseNoBalance <= 1'b0;
      dispenseBalance   <= 1'b0;
      changeNickel      <= 1'b0;
      coinReject        <= 1'b0;

      case (state)
        COLLECT: begin
          busy <= 1'b0;
          if (one_coin) begin
            count <= sum[CREDIT_W-1:0];
            if (sum >= PRICE_X) begin
              state <= DISPENSE;
              busy  <= 1'b1;
            end
          end else if (any_coin) begin
            coinReject <= 1'b1;
          end else if (cancel && (count != '0)) begin
            state <= CHANGE;
            busy  <= 1'b1;
          end
        end

        DISPENSE: begin
          coinReject <= any_coin;
          count      <= count - PRICE_C;
          if (count == PRICE_C) begin
            dispenseNoBalance <= 1'b1;
            state             <= COLLECT;
            busy              <= 1'b0;
          end else begin
            dispenseBalance <= 1'b1;
            state           <= CHANGE;
            busy            <= 1'b1;
          end
        end

        CHANGE: begin
          coinReject   <= any_coin;
          changeNickel <= 1'b1;
          count        <= count - UNIT_C;
          if (count <= UNIT_C) begin
            state <= COLLECT;
            busy  <= 1'b0;
          end else begin
            busy <= 1'b1;
          end
        end

        default: begin
          state <= COLLECT;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vending_controller.sv
// Bench for vending_controller: directed scenarios then random coin/cancel/reset
// traffic, checked each cycle against a schedule-based credit model.
module tb_vending_controller;

  localparam int PRICE = 60;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       nickel = 1'b0;
  logic       dime   = 1'b0;
  logic       quarter = 1'b0;
  logic       cancel = 1'b0;
  logic       dispenseNoBalance;
  logic       dispenseBalance;
  logic       changeNickel;
  logic       coinReject;
  logic       busy;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;

  // Each entry is the output picture expected after one future clock edge.
  typedef struct {
    bit dnb;
    bit db;
    bit cn;
    int cnt;
  } ev_t;

  ev_t      sched[$];
  int       credit;
  bit [2:0] pm;
  bit       e_dnb, e_db, e_cn, e_rej, e_busy;
  int       e_cnt;

  vending_controller #(
    .PRICE      (60),
    .NICKEL_VAL (5),
    .DIME_VAL   (10),
    .QUARTER_VAL(25),
    .CREDIT_W   (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .nickel           (nickel),
    .dime             (dime),
    .quarter          (quarter),
    .cancel           (cancel),
    .dispenseNoBalance(dispenseNoBalance),
    .dispenseBalance  (dispenseBalance),
    .changeNickel     (changeNickel),
    .coinReject       (coinReject),
    .busy             (busy),
    .count            (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dnb"},   {31'd0, dispenseNoBalance}, {31'd0, e_dnb});
    chk({tag, ".db"},    {31'd0, dispenseBalance},   {31'd0, e_db});
    chk({tag, ".cn"},    {31'd0, changeNickel},      {31'd0, e_cn});
    chk({tag, ".rej"},   {31'd0, coinReject},        {31'd0, e_rej});
    chk({tag, ".busy"},  {31'd0, busy},              {31'd0, e_busy});
    chk({tag, ".count"}, {24'd0, count},             e_cnt);
  endtask

  task automatic model_reset();
    sched.delete();
    credit = 0;
    pm     = 3'b111;
    e_dnb  = 0; e_db = 0; e_cn = 0; e_rej = 0; e_busy = 0;
    e_cnt  = 0;
  endtask

  task automatic model_step(input bit n, input bit d, input bit q, input bit c);
    bit [2:0] cur;
    bit [2:0] r;
    int       nr;
    int       rem;
    ev_t      e;
    cur = {n, d, q};
    r   = cur & ~pm;
    nr  = $countones(r);
    pm  = cur;
    e_dnb = 0; e_db = 0; e_cn = 0; e_rej = 0;
    if (sched.size() > 0) begin
      e      = sched.pop_front();
      e_dnb  = e.dnb;
      e_db   = e.db;
      e_cn   = e.cn;
      e_rej  = (nr > 0);
      credit = e.cnt;
    end else if (nr == 1) begin
      credit += r[2] ? 5 : (r[1] ? 10 : 25);
      if (credit >= PRICE) begin
        rem = credit - PRICE;
        sched.push_back('{rem == 0, rem != 0, 1'b0, rem});
        for (int k = 1; k <= rem / 5; k++) sched.push_back('{1'b0, 1'b0, 1'b1, rem - 5 * k});
      end
    end else if (nr > 1) begin
      e_rej = 1;
    end else if (c && credit > 0) begin
      for (int k = 1; k <= credit / 5; k++) sched.push_back('{1'b0, 1'b0, 1'b1, credit - 5 * k});
    end
    e_busy = (sched.size() > 0);
    e_cnt  = credit;
  endtask

  task automatic cycle(input bit n, input bit d, input bit q, input bit c, input string tag);
    nickel  = n;
    dime    = d;
    quarter = q;
    cancel  = c;
    @(posedge clk);
    model_step(n, d, q, c);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int k, input string tag);
    for (int i = 0; i < k; i++) cycle(0, 0, 0, 0, tag);
  endtask

  task automatic apply_reset(input bit hold_q, input string tag);
    #2;
    reset   = 1'b1;
    nickel  = 1'b0;
    dime    = 1'b0;
    quarter = hold_q;
    cancel  = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".async"});
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;
    idle(1, "post_reset");

    // Sequential coins ending in change
    cycle(1, 0, 0, 0, "seq.n");  idle(1, "seq");
    cycle(0, 1, 0, 0, "seq.d");  idle(1, "seq");
    cycle(0, 0, 1, 0, "seq.q1"); idle(1, "seq");
    cycle(0, 0, 1, 0, "seq.q2");
    chk("seq.count65", {24'd0, count}, 65);
    cycle(0, 0, 0, 0, "seq.vend");
    chk("seq.dispenseBalance", {31'd0, dispenseBalance}, 1);
    chk("seq.count5", {24'd0, count}, 5);
    cycle(0, 0, 0, 0, "seq.change");
    chk("seq.changeNickel", {31'd0, changeNickel}, 1);
    cycle(0, 0, 0, 0, "seq.done");
    chk("seq.busy0", {31'd0, busy}, 0);

    // Exact payment
    cycle(0, 0, 1, 0, "exact.q1"); idle(1, "exact");
    cycle(0, 0, 1, 0, "exact.q2"); idle(1, "exact");
    cycle(0, 1, 0, 0, "exact.d");
    chk("exact.count60", {24'd0, count}, 60);
    cycle(0, 0, 0, 0, "exact.vend");
    chk("exact.dnb", {31'd0, dispenseNoBalance}, 1);
    idle(2, "exact.after");

    // Held quarter credits once, then refund it
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 0, "held.q");
    chk("held.count25", {24'd0, count}, 25);
    cycle(0, 0, 0, 1, "held.cancel");
    idle(6, "held.refund");

    // Refund of 35 cents
    cycle(0, 1, 0, 0, "refund.d"); idle(1, "refund");
    cycle(0, 0, 1, 0, "refund.q"); idle(1, "refund");
    chk("refund.count35", {24'd0, count}, 35);
    cycle(0, 0, 0, 1, "refund.cancel");
    for (int i = 1; i <= 7; i++) begin
      cycle(0, 0, 0, 0, "refund.pulse");
      chk("refund.cn", {31'd0, changeNickel}, 1);
      chk("refund.count", {24'd0, count}, 35 - 5 * i);
    end
    idle(1, "refund.done");

    // Rejections: double coin, and a coin arriving during change
    cycle(0, 1, 1, 0, "rej.double");
    chk("rej.double.flag", {31'd0, coinReject}, 1);
    idle(1, "rej");
    cycle(0, 1, 0, 0, "rej.d"); idle(1, "rej");
    cycle(0, 0, 0, 1, "rej.cancel");
    cycle(1, 0, 0, 0, "rej.nickel_in_change");
    idle(3, "rej.tail");

    // Reset on the 3rd refund nickel with quarter held through release
    cycle(0, 1, 0, 0, "rst.d"); idle(1, "rst");
    cycle(0, 0, 1, 0, "rst.q"); idle(1, "rst");
    cycle(0, 0, 0, 1, "rst.cancel");
    idle(3, "rst.pulses");
    apply_reset(1, "rst.mid");
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, "rst.held_q");
    chk("rst.count0", {24'd0, count}, 0);
    idle(1, "rst.tail");

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        apply_reset(1'($urandom_range(0, 1)), "rnd.reset");
      end else begin
        cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
